// File: rtl/tt_response_checker_pkg.sv
// Shared definitions for the truth-table response checker: FSM state
// encodings, vector space size and a helper for the dwell counter width.
package tt_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;

    // Counter width for a dwell of n cycles; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tt_response_checker_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and wraps. Flags the cycle
// at which the DUT output is sampled and the final cycle of each dwell.
module tt_dwell_counter
    import tt_defs::*;
#(
    parameter int DWELL     = 20,
    parameter int SAMPLE_AT = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic sample_pulse,
    output logic last_pulse
);

    localparam int                 CNT_W    = cnt_width(DWELL);
    localparam logic [CNT_W-1:0]   SAMPLE_V = CNT_W'(SAMPLE_AT);
    localparam logic [CNT_W-1:0]   LAST_V   = CNT_W'(DWELL - 1);

    // Reject parameterisations that can never sample inside a dwell.
    if (DWELL < 1) begin : g_bad_dwell
        $error("tt_dwell_counter: DWELL must be at least 1");
    end
    if ((SAMPLE_AT < 0) || (SAMPLE_AT > DWELL - 1)) begin : g_bad_sample
        $error("tt_dwell_counter: SAMPLE_AT must lie in 0..DWELL-1");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sample_pulse = en && (cnt_q == SAMPLE_V);
    assign last_pulse   = en && (cnt_q == LAST_V);

    // Next count: clear wins, otherwise step and wrap at the end of a dwell.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_response_checker.sv
// Truth-table response checker: sweeps all 16 {a,b,c,d} vectors into a
// combinational DUT, samples f once per vector, and compares the captured
// table with EXPECTED. Optional macro TT_FIRST_FAIL_EN adds fail_valid and
// fail_idx, reporting the first vector whose response was wrong.
module tt_response_checker
    import tt_defs::*;
#(
    parameter int          DWELL     = 20,
    parameter int          SAMPLE_AT = 19,
    parameter logic [15:0] EXPECTED  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured
`ifdef TT_FIRST_FAIL_EN
    ,
    output logic        fail_valid,
    output logic [3:0]  fail_idx
`endif
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_t               state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [NUM_VEC-1:0]   captured_q, captured_d;
`ifdef TT_FIRST_FAIL_EN
    logic                 fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0]     fail_idx_q, fail_idx_d;
`endif

    logic sweep_start;
    logic sample_pulse;
    logic last_pulse;

    // A sweep may only be launched from IDLE or DONE; start during RUN is ignored.
    assign sweep_start = start && (state_q != ST_RUN);

    tt_dwell_counter #(
        .DWELL     (DWELL),
        .SAMPLE_AT (SAMPLE_AT)
    ) u_dwell (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (sweep_start),
        .en           (state_q == ST_RUN),
        .sample_pulse (sample_pulse),
        .last_pulse   (last_pulse)
    );

    // Next-state and datapath: launch, capture f per vector, judge at the end.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        captured_d = captured_q;
`ifdef TT_FIRST_FAIL_EN
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    vec_d      = '0;
                    captured_d = '0;
`ifdef TT_FIRST_FAIL_EN
                    fail_valid_d = 1'b0;
                    fail_idx_d   = '0;
`endif
                end
            end
            ST_RUN: begin
                if (sample_pulse) begin
                    captured_d[vec_q] = f;
`ifdef TT_FIRST_FAIL_EN
                    if (!fail_valid_q && (f != EXPECTED[vec_q])) begin
                        fail_valid_d = 1'b1;
                        fail_idx_d   = vec_q;
                    end
`endif
                end
                if (last_pulse) begin
                    if (vec_q == LAST_VEC) begin
                        // captured_d already holds this cycle's sample for vector 15.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (captured_d == EXPECTED);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
`ifdef TT_FIRST_FAIL_EN
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
`ifdef TT_FIRST_FAIL_EN
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
`endif
        end
    end

    // The vector register drives the DUT directly; it rests at 15 in DONE.
    assign a        = vec_q[3];
    assign b        = vec_q[2];
    assign c        = vec_q[1];
    assign d        = vec_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = captured_q;
`ifdef TT_FIRST_FAIL_EN
    assign fail_valid = fail_valid_q;
    assign fail_idx   = fail_idx_q;
`endif

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Synthesizable counterpart to the exhaustive 4-input stimulus bench: drives all 16 {a,b,c,d} combinations to a combinational DUT and reads back its single output f.
- Builds a captured 16-bit truth table, compares it with an expected table, and reports pass/fail.
- Sits beside a lab DUT on the FPGA, so the check runs in hardware rather than in a simulation-only bench.

Parameters:
- DWELL, 20, clock cycles each vector is held on a/b/c/d (min 1).
- SAMPLE_AT, 19, cycle index within the dwell at which f is sampled (0..DWELL-1).
- EXPECTED, 16'h0000, expected truth table; bit i is the required f for vector i.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled in IDLE/DONE, begins a sweep.
- f  input  1  DUT output under test.
- a  output  1  DUT input, MSB of vector.
- b  output  1  DUT input.
- c  output  1  DUT input.
- d  output  1  DUT input, LSB of vector.
- busy  output  1  high while sweeping.
- done  output  1  high in DONE until next start.
- pass  output  1  valid when done=1; 1 iff captured==EXPECTED.
- captured  output  16  captured truth table; bit i is f sampled for vector i.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; vec=0; cnt=0; a=b=c=d=0; busy=0; done=0; pass=0; captured=16'h0000.
- Vector mapping: {a,b,c,d}=vec[3:0], so vector i drives A as MSB. Order is 0..15 ascending.
- All outputs are registered. The dwell counter is $clog2(DWELL) bits wide, minimum 1.
- IDLE:
  - On start=1 at an edge: next cycle state=RUN, busy=1, vec=0, cnt=0, captured=0.
- RUN:
  - Outputs abcd hold vec. cnt increments each cycle.
  - When cnt==SAMPLE_AT: captured[vec] <= f.
  - When cnt==DWELL-1 and vec<15: vec++, cnt=0.
  - When cnt==DWELL-1 and vec==15: state=DONE; busy=0; done=1; pass=({f-sampled table}==EXPECTED). Same-cycle capture at vec 15 is included in the comparison.
- Sweep length: exactly 16*DWELL cycles with busy=1; done rises on the following edge.
- DONE:
  - abcd hold 4'b1111. done, pass and captured are held.
  - start=1: restart exactly as from IDLE, clearing done and pass on the next cycle.
- start while RUN: ignored, no restart.
- Reset mid-run: immediate return to reset values; no partial result is reported.
- DWELL=1 boundary: SAMPLE_AT must be 0; one vector per cycle; the sweep is 16 cycles.
- SAMPLE_AT > DWELL-1: illegal parameterisation, flagged by an elaboration check.
- f is treated as synchronous to clk. The bench or top level provides a DUT settle time of at least SAMPLE_AT cycles.

Optional Feature:
- Macro: TT_FIRST_FAIL_EN.
- Defined: adds outputs fail_valid (1) and fail_idx (4).
  - On the first vector whose sampled f != EXPECTED[vec], latch fail_idx=vec and set fail_valid=1.
  - Later mismatches do not overwrite the latched index.
  - Both are cleared at reset and on sweep start.
- Undefined: these ports and registers do not exist; pass is the only verdict.

Decomposition:
- Shared package/header tt_defs:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - NUM_VEC=16, VEC_W=4.
- One natural sub-module: tt_dwell_counter.
  - Parameterised by DWELL and SAMPLE_AT.
  - Inputs clr, en; outputs sample_pulse and last_pulse.
  - The FSM and capture logic stay in the top module.

Test Plan:
- AND4 DUT (f=a&b&c&d), EXPECTED=16'h8000, DWELL=20, pulse start -> busy high for 320 cycles, then done=1, pass=1, captured=16'h8000.
- XOR4 DUT, EXPECTED=16'h8000 -> done=1, pass=0, captured=16'h6996; with TT_FIRST_FAIL_EN, fail_valid=1 and fail_idx=1.
- Assert rst_n=0 at cycle 100 of a sweep -> abcd=0, busy=0, done=0 and captured=0 immediately; start after release gives a full clean sweep.
- Hold start=1 continuously during RUN -> no restart, done at cycle 320 as normal. Holding start in DONE restarts the sweep on the next cycle.
- DWELL=1, SAMPLE_AT=0, f=a|d, EXPECTED=16'hFFAA -> 16 busy cycles; abcd steps 0..15 one per cycle; pass=1.
- Two back-to-back sweeps with DUT changed between them (AND4 then OR4, EXPECTED=16'h8000) -> first pass=1, second pass=0 with captured=16'hFFFE, proving captured is cleared on restart.
